// File: rtl/cdb_arbiter_if.sv
// Bundle of the functional-unit result lanes and the published CDB outputs.
// The master drives lane requests/results; the slave (arbiter) returns grants and the CDB.
interface cdb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
);
    logic [3:0]          fu_req;
    logic [4*TAG_W-1:0]  fu_tag;
    logic [4*DATA_W-1:0] fu_data;
    logic                flush;
    logic [3:0]          fu_grant;
    logic                cdb_valid;
    logic [TAG_W-1:0]    cdb_tag;
    logic [DATA_W-1:0]   cdb_data;
    logic [1:0]          cdb_src;

    modport master (
        output fu_req, fu_tag, fu_data, flush,
        input  fu_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );

    modport slave (
        input  fu_req, fu_tag, fu_data, flush,
        output fu_grant, cdb_valid, cdb_tag, cdb_data, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one Common Data Bus among four result lanes.
// Grant is combinational; the winning lane's tag/result is registered onto the CDB.
module cdb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 6
) (
    input logic        clk_i,
    input logic        reset_i,
    cdb_arbiter_if.slave bus_io
);
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [1:0]        cdb_src_q, cdb_src_d;

    logic              gnt_any;
    logic [1:0]        gnt_idx;
    logic [1:0]        cand;
    logic [3:0]        grant;

    // Search from rr_ptr upward with 2-bit wrap; first requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!gnt_any && bus_io.fu_req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (reset_i || bus_io.flush) begin
            gnt_any = 1'b0;
        end
        grant = gnt_any ? (4'b0001 << gnt_idx) : 4'b0000;
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = gnt_any;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (gnt_any) begin
            rr_ptr_d   = gnt_idx + 2'd1;
            cdb_tag_d  = bus_io.fu_tag[TAG_W * 32'(gnt_idx) +: TAG_W];
            cdb_data_d = bus_io.fu_data[DATA_W * 32'(gnt_idx) +: DATA_W];
            cdb_src_d  = gnt_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_ptr_q    <= 2'd0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= 2'd0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
        end
    end

    assign bus_io.fu_grant  = grant;
    assign bus_io.cdb_valid = cdb_valid_q;
    assign bus_io.cdb_tag   = cdb_tag_q;
    assign bus_io.cdb_data  = cdb_data_q;
    assign bus_io.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter: table of per-cycle stimulus with expected
// grant, CDB contents and pointer, followed by back-to-back and fairness sequences.
module tb_cdb_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    localparam int NVEC = 25;

    typedef struct {
        logic       rst;
        logic       flush;
        logic [3:0] req;
        logic [3:0] gnt;  // expected combinational grant this cycle
        logic       vld;  // expected cdb_valid after the edge
        logic       z;    // CDB payload expected zero (reset) after the edge
        logic [1:0] src;  // expected cdb_src after the edge
        logic [1:0] ptr;  // expected rr_ptr after the edge
    } vec_t;

    logic clk_i = 1'b0;
    logic reset_i;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [TAG_W-1:0]  lane_tag  [4];
    logic [DATA_W-1:0] lane_data [4];
    vec_t vecs [NVEC];

    cdb_arbiter_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus_io  (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_lanes();
        bus.fu_tag  = {lane_tag[3], lane_tag[2], lane_tag[1], lane_tag[0]};
        bus.fu_data = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};
    endtask

    initial begin
        logic [TAG_W-1:0]  exp_tag;
        logic [DATA_W-1:0] exp_data;
        logic              got;

        lane_tag[0] = 6'h11; lane_data[0] = 32'h1111_0000;
        lane_tag[1] = 6'h22; lane_data[1] = 32'h2222_1111;
        lane_tag[2] = 6'h2A; lane_data[2] = 32'hDEAD_BEEF;
        lane_tag[3] = 6'h3C; lane_data[3] = 32'h3333_CAFE;

        //             rst flush req      gnt      vld z  src    ptr
        vecs[0]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, 2'd3};
        vecs[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd1};
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0, 2'd2, 2'd3};
        vecs[6]  = '{1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0, 2'd3, 2'd0};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd1};
        vecs[8]  = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[9]  = '{1'b0, 1'b0, 4'b1111, 4'b0100, 1'b1, 1'b0, 2'd2, 2'd3};
        vecs[10] = '{1'b0, 1'b0, 4'b1111, 4'b1000, 1'b1, 1'b0, 2'd3, 2'd0};
        vecs[11] = '{1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[12] = '{1'b0, 1'b0, 4'b1010, 4'b1000, 1'b1, 1'b0, 2'd3, 2'd0};
        vecs[13] = '{1'b0, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[14] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 2'd2};
        vecs[15] = '{1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 2'd2};
        vecs[16] = '{1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 1'b0, 2'd0, 2'd1};
        vecs[17] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[18] = '{1'b0, 1'b0, 4'b1111, 4'b0010, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[19] = '{1'b0, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1, 2'd2};
        vecs[20] = '{1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd2, 2'd3};
        vecs[21] = '{1'b1, 1'b0, 4'b1010, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[22] = '{1'b0, 1'b0, 4'b1010, 4'b0010, 1'b1, 1'b0, 2'd1, 2'd2};
        vecs[23] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0};
        vecs[24] = '{1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 2'd3, 2'd0};

        reset_i    = 1'b1;
        bus.flush  = 1'b0;
        bus.fu_req = 4'b0000;
        drive_lanes();

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk_i);
            reset_i    = vecs[i].rst;
            bus.flush  = vecs[i].flush;
            bus.fu_req = vecs[i].req;
            drive_lanes();
            #1;
            check($sformatf("v%0d_grant", i), 64'(bus.fu_grant), 64'(vecs[i].gnt));
            @(posedge clk_i);
            #1;
            exp_tag  = vecs[i].z ? '0 : lane_tag[vecs[i].src];
            exp_data = vecs[i].z ? '0 : lane_data[vecs[i].src];
            check($sformatf("v%0d_valid", i), 64'(bus.cdb_valid), 64'(vecs[i].vld));
            check($sformatf("v%0d_src", i), 64'(bus.cdb_src), 64'(vecs[i].src));
            check($sformatf("v%0d_tag", i), 64'(bus.cdb_tag), 64'(exp_tag));
            check($sformatf("v%0d_data", i), 64'(bus.cdb_data), 64'(exp_data));
            check($sformatf("v%0d_ptr", i), 64'(dut.rr_ptr_q), 64'(vecs[i].ptr));
        end

        // Back-to-back results from lane 0 with request held high.
        @(negedge clk_i);
        bus.fu_req   = 4'b0001;
        lane_tag[0]  = 6'h05;
        lane_data[0] = 32'h0000_0005;
        drive_lanes();
        #1;
        check("b2b_grant0", 64'(bus.fu_grant), 64'h1);
        @(posedge clk_i);
        #1;
        check("b2b_tag0", 64'(bus.cdb_tag), 64'h05);
        check("b2b_valid0", 64'(bus.cdb_valid), 64'h1);
        @(negedge clk_i);
        lane_tag[0]  = 6'h06;
        lane_data[0] = 32'h0000_0006;
        drive_lanes();
        #1;
        check("b2b_grant1", 64'(bus.fu_grant), 64'h1);
        @(posedge clk_i);
        #1;
        check("b2b_tag1", 64'(bus.cdb_tag), 64'h06);
        check("b2b_data1", 64'(bus.cdb_data), 64'h6);

        // Fairness: lane 3 must win within four cycles while all lanes compete.
        got = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            bus.fu_req = 4'b1111;
            #1;
            if (!got && bus.fu_grant[3]) got = 1'b1;
        end
        check("fair_lane3", 64'(got), 64'h1);

        @(negedge clk_i);
        bus.fu_req = 4'b0000;
        @(posedge clk_i);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single Common Data Bus (CDB) among four functional-unit result lanes: integer ALU, load/store, multiplier, divider. Each cycle it grants at most one requesting lane and registers that lane's tag and result onto the CDB. The registered outputs feed the register status table clear port (`cdb_tag`/`cdb_valid`), the reservation-station wakeup logic and the register-file write path.

## Interface
Parameters:
- `DATA_W`, 32, width of the result payload.
- `TAG_W`, 6, width of the rename tag.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fu_req`  in  4  per-lane request. Bit 0 int, 1 ld/st, 2 mult, 3 div.
- `fu_tag`  in  4*TAG_W  packed tags. Lane i at `[i*TAG_W +: TAG_W]`.
- `fu_data`  in  4*DATA_W  packed results. Lane i at `[i*DATA_W +: DATA_W]`.
- `flush`  in  1  branch-mispredict flush. Suppresses grant and publication this cycle.
- `fu_grant`  out  4  combinational one-hot grant, same cycle as the request.
- `cdb_valid`  out  1  registered: CDB carries a valid result.
- `cdb_tag`  out  TAG_W  registered published tag.
- `cdb_data`  out  DATA_W  registered published result.
- `cdb_src`  out  2  registered index of the lane that was published.

## Operation
- State: `rr_ptr[1:0]`, the highest-priority lane for the current cycle.
- Search order: `rr_ptr`, `rr_ptr+1`, `rr_ptr+2`, `rr_ptr+3`, all mod 4. The first lane with `fu_req` set wins. `fu_grant` is one-hot for that lane.
- On a grant to lane g: `rr_ptr <= (g+1) mod 4`, with natural 2-bit wrap (lane 3 grants -> ptr 0).
- No request, or `flush`=1: `fu_grant`=0 and `rr_ptr` holds.
- Handshake:
  - A lane holds `fu_req`, tag and data stable until it sees `fu_grant[i]`=1 at a clock edge.
  - The transfer happens at that edge.
  - The lane may present a new result with `fu_req` still high in the next cycle.
  - A request is never dropped. An ungranted lane simply retries.
- Publication: at the edge after a grant, the registers load `cdb_valid<=1`, `cdb_tag<=fu_tag[g]`, `cdb_data<=fu_data[g]`, `cdb_src<=g`. Otherwise `cdb_valid<=0`.
- When `cdb_valid`=0, `cdb_tag`, `cdb_data` and `cdb_src` hold their last values. Consumers must qualify them with `cdb_valid`.
- Fairness: a continuously requesting lane is granted within 4 cycles.

## Timing
- Reset (sync, active-high) loads `rr_ptr=0`, `cdb_valid=0`, `cdb_tag=0`, `cdb_data=0`, `cdb_src=0`.
- `fu_grant` is forced to 0 in any cycle where `reset`=1, regardless of `fu_req`.
- Latency: request granted in cycle N -> on CDB in cycle N+1. Throughput is one result per cycle.
- `fu_grant` is pure combinational from `fu_req`, `rr_ptr`, `flush` and `reset`. There is no path from `fu_tag` or `fu_data` to the grant.
- `flush` in cycle N:
  - No grant in N, and `cdb_valid`=0 in N+1.
  - A result already on the CDB in cycle N (granted in N-1) is not retracted.
- Simultaneous `reset` and `flush`: reset wins (identical observable result).
- Reset asserted while a lane is waiting: the lane is not granted. After reset, arbitration restarts from lane 0.

## Test plan
- Reset, then only `fu_req=4'b0100` with tag 6'h2A, data 32'hDEADBEEF:
  - `fu_grant=4'b0100` same cycle.
  - Next cycle `cdb_valid=1`, `cdb_tag=2A`, `cdb_data=DEADBEEF`, `cdb_src=2`.
  - `rr_ptr` becomes 3.
- All four lanes requesting continuously for 8 cycles after reset -> grants 0,1,2,3,0,1,2,3. `cdb_src` follows one cycle later.
- Lanes 1 and 3 requesting with `rr_ptr=2` -> lane 3 granted, then lane 1. Wraps to ptr 0, then 2.
- `flush`=1 for one cycle with `fu_req=4'b1111` and `rr_ptr=1`:
  - `fu_grant=0`; next cycle `cdb_valid=0`.
  - Cycle after flush grants lane 1 (pointer unchanged).
- `reset` pulsed mid-stream with `fu_req=4'b1010` and `rr_ptr=3`:
  - No grant during reset; outputs zero the next cycle.
  - First post-reset grant is lane 1.
- Idle cycles (`fu_req=0`) between grants -> `cdb_valid=0`, `rr_ptr` unchanged, and the held `cdb_tag` is unchanged.
